// File: rtl/display_serial_driver_if.sv
// Front-panel display serial bus as it leaves the driver: latch, blank,
// chip-select, serial clock and serial data.
interface display_x;
  logic       latch_o;
  logic       blank_o;
  logic [2:0] csel_ob3;
  logic       sclk_o;
  logic       data_o;

  modport master (output latch_o, blank_o, csel_ob3, sclk_o, data_o);
  modport slave  (input  latch_o, blank_o, csel_ob3, sclk_o, data_o);
endinterface

// File: rtl/display_serial_driver.sv
// Refreshes the shift-register LED drivers one chip-select group at a time,
// shifting each group MSB first from a frame-coherent shadow of the image.
module display_serial_driver #(
  parameter int NUM_GROUPS  = 8,
  parameter int GROUP_BITS  = 16,
  parameter int HALF_PERIOD = 2
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [NUM_GROUPS*GROUP_BITS-1:0] image_ib,
  input  logic                             blank_i,
  input  logic                             enable_i,
  output logic                             frame_done_o,
  output logic                             busy_o,
  display_x.master                         display
);

  localparam int GRP_W = (NUM_GROUPS  > 1) ? $clog2(NUM_GROUPS)  : 1;
  localparam int BIT_W = (GROUP_BITS  > 1) ? $clog2(GROUP_BITS)  : 1;
  localparam int CNT_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SCLK_LO,
    S_SCLK_HI,
    S_LATCH,
    S_GAP
  } state_t;

  state_t                  state_q, state_d;
  logic [GRP_W-1:0]        group_q, group_d;
  logic [BIT_W-1:0]        bitIdx_q, bitIdx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [GROUP_BITS-1:0]   shadow_q [NUM_GROUPS];
  logic                    firstFrame_q, firstFrame_d;
  logic                    frameDone_q, frameDone_d;
  logic                    blank_q;
  logic [1:0]              rstSync_q;
  logic                    rstInt_n;
  logic                    tick;
  logic                    loadEn;
  logic                    shifting;

  // Reset asserts immediately but releases two clocks later, in step with clk.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rstSync_q <= '0;
    else       rstSync_q <= {rstSync_q[0], 1'b1};
  end

  assign rstInt_n = rstSync_q[1];
  assign tick     = (cnt_q == CNT_W'(HALF_PERIOD - 1));

  always_ff @(posedge clk or negedge rstInt_n) begin
    if (!rstInt_n) begin
      state_q      <= S_IDLE;
      group_q      <= '0;
      bitIdx_q     <= '0;
      cnt_q        <= '0;
      firstFrame_q <= 1'b0;
      frameDone_q  <= 1'b0;
      blank_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      group_q      <= group_d;
      bitIdx_q     <= bitIdx_d;
      cnt_q        <= cnt_d;
      firstFrame_q <= firstFrame_d;
      frameDone_q  <= frameDone_d;
      blank_q      <= blank_i | ~firstFrame_q;
    end
  end

  // The shadow only changes in LOAD, so mid-frame image edits never tear.
  always_ff @(posedge clk or negedge rstInt_n) begin
    if (!rstInt_n) begin
      for (int g = 0; g < NUM_GROUPS; g++) shadow_q[g] <= '0;
    end else if (loadEn) begin
      for (int g = 0; g < NUM_GROUPS; g++)
        shadow_q[g] <= image_ib[g*GROUP_BITS +: GROUP_BITS];
    end
  end

  always_comb begin
    state_d      = state_q;
    group_d      = group_q;
    bitIdx_d     = bitIdx_q;
    frameDone_d  = 1'b0;
    firstFrame_d = firstFrame_q;
    loadEn       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (enable_i) state_d = S_LOAD;
      end
      S_LOAD: begin
        loadEn   = 1'b1;
        group_d  = '0;
        bitIdx_d = BIT_W'(GROUP_BITS - 1);
        state_d  = S_SCLK_LO;
      end
      S_SCLK_LO: begin
        if (tick) state_d = S_SCLK_HI;
      end
      S_SCLK_HI: begin
        if (tick) begin
          if (bitIdx_q == '0) begin
            state_d = S_LATCH;
          end else begin
            bitIdx_d = bitIdx_q - 1'b1;
            state_d  = S_SCLK_LO;
          end
        end
      end
      S_LATCH: begin
        if (tick) state_d = S_GAP;
      end
      S_GAP: begin
        if (tick) begin
          if (group_q == GRP_W'(NUM_GROUPS - 1)) begin
            frameDone_d  = 1'b1;
            firstFrame_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            group_d  = group_q + 1'b1;
            bitIdx_d = BIT_W'(GROUP_BITS - 1);
            state_d  = S_SCLK_LO;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_d != state_q) || tick) cnt_d = '0;
    else                              cnt_d = cnt_q + 1'b1;
  end

  assign shifting         = (state_q == S_SCLK_LO) || (state_q == S_SCLK_HI);
  assign display.sclk_o   = (state_q == S_SCLK_HI);
  assign display.latch_o  = (state_q == S_LATCH);
  assign display.data_o   = shifting ? shadow_q[group_q][bitIdx_q] : 1'b0;
  assign display.csel_ob3 = 3'(group_q);
  assign display.blank_o  = blank_q;
  assign frame_done_o     = frameDone_q;
  assign busy_o           = (state_q != S_IDLE);

endmodule

// File: tb/tb_display_serial_driver.sv
// Scoreboard bench: expected per-group latched words are queued when an image
// is launched and matched against words reassembled from the serial bus.
module tb_display_serial_driver;
  localparam int NG = 8;
  localparam int GB = 16;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [NG*GB-1:0] image = '0;
  logic            blankIn = 1'b0;
  logic            enableIn = 1'b0;
  logic            frameDone;
  logic            busy;

  display_x dispIf ();

  display_serial_driver #(.NUM_GROUPS(NG), .GROUP_BITS(GB), .HALF_PERIOD(2)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .image_ib     (image),
    .blank_i      (blankIn),
    .enable_i     (enableIn),
    .frame_done_o (frameDone),
    .busy_o       (busy),
    .display      (dispIf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  csel;
    logic [15:0] word;
  } exp_t;

  typedef struct {
    logic [2:0]  csel;
    logic [15:0] word;
    int          edges;
    int          minHigh;
    int          maxHigh;
    int          latchLen;
  } cap_t;

  exp_t expQ[$];
  cap_t capQ[$];
  int   checks = 0;
  int   passes = 0;

  logic        monPrevSclk, monPrevLatch;
  logic [15:0] monShift;
  int          monEdges, monHiRun, monMinHi, monMaxHi, monLatRun;
  cap_t        monCap;

  // Reassemble each group from the bus; one capture per latch pulse.
  always @(negedge clk) begin
    if (!rstn) begin
      monPrevSclk = 1'b0; monPrevLatch = 1'b0; monShift = '0;
      monEdges = 0; monHiRun = 0; monMinHi = 1000; monMaxHi = 0; monLatRun = 0;
    end else begin
      if (dispIf.sclk_o) monHiRun++;
      if (dispIf.sclk_o && !monPrevSclk) begin
        monShift = {monShift[14:0], dispIf.data_o};
        monEdges++;
      end
      if (!dispIf.sclk_o && monPrevSclk) begin
        if (monHiRun < monMinHi) monMinHi = monHiRun;
        if (monHiRun > monMaxHi) monMaxHi = monHiRun;
        monHiRun = 0;
      end
      if (dispIf.latch_o) monLatRun++;
      if (!dispIf.latch_o && monPrevLatch) begin
        monCap.csel = dispIf.csel_ob3;
        monCap.word = monShift;
        monCap.edges = monEdges;
        monCap.minHigh = monMinHi;
        monCap.maxHigh = monMaxHi;
        monCap.latchLen = monLatRun;
        capQ.push_back(monCap);
        monEdges = 0; monMinHi = 1000; monMaxHi = 0; monLatRun = 0;
      end
      monPrevSclk = dispIf.sclk_o;
      monPrevLatch = dispIf.latch_o;
    end
  end

  task automatic pushFrame(input logic [NG*GB-1:0] img);
    exp_t e;
    for (int g = 0; g < NG; g++) begin
      e.csel = 3'(g);
      e.word = img[g*GB +: GB];
      expQ.push_back(e);
    end
  endtask

  task automatic waitBusy(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic waitFrameDone(output int cycles, output bit ok);
    ok = 1'b0;
    cycles = 0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      cycles++;
      if (frameDone) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    logic [8:0] obs;
    repeat (3) @(negedge clk);
    obs = {dispIf.latch_o, dispIf.sclk_o, dispIf.data_o, dispIf.csel_ob3,
           dispIf.blank_o, frameDone, busy};
    checks++;
    if (obs !== 9'b0_0_0_000_1_0_0)
      $display("[TB] FAIL reset_outputs: got %b expected %b", obs, 9'b0_0_0_000_1_0_0);
    else passes++;
  endtask

  task automatic test_first_frame();
    bit ok;
    int cycles, blankBad;
    exp_t e;
    cap_t c;
    image = '0;
    capQ.delete();
    pushFrame(image);
    rstn = 1'b1;
    enableIn = 1'b1;
    waitBusy(ok);
    checks++;
    if (!ok) $display("[TB] FAIL first_busy: busy=0 after 50 cycles, expected 1");
    else passes++;
    cycles = 0; blankBad = 0; ok = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      cycles++;
      if (dispIf.blank_o !== 1'b1) blankBad++;
      if (frameDone) begin ok = 1'b1; break; end
    end
    enableIn = 1'b0;
    checks++;
    if (!ok || cycles != 545)
      $display("[TB] FAIL first_done_latency: got %0d cycles (seen=%0d) expected 545", cycles, ok);
    else passes++;
    checks++;
    if (blankBad != 0)
      $display("[TB] FAIL blank_before_first: %0d cycles unblanked, expected 0", blankBad);
    else passes++;
    @(negedge clk);
    checks++;
    if (dispIf.blank_o !== 1'b0)
      $display("[TB] FAIL blank_after_first: got %b expected 0", dispIf.blank_o);
    else passes++;
    for (int g = 0; g < NG; g++) begin
      e = expQ.pop_front();
      checks++;
      if (capQ.size() == 0) begin
        $display("[TB] FAIL first_capture: group %0d missing, expected word %h", g, e.word);
        continue;
      end
      c = capQ.pop_front();
      if (c.csel !== e.csel || c.word !== e.word)
        $display("[TB] FAIL first_word: got csel %0d word %h expected csel %0d word %h",
                 c.csel, c.word, e.csel, e.word);
      else passes++;
    end
  endtask

  task automatic test_pattern_timing();
    bit ok;
    int cycles;
    exp_t e;
    cap_t c;
    image = '0;
    image[3*GB +: GB] = 16'hA5C3;
    capQ.delete();
    pushFrame(image);
    enableIn = 1'b1;
    waitBusy(ok);
    enableIn = 1'b0;
    waitFrameDone(cycles, ok);
    checks++;
    if (!ok || cycles != 545)
      $display("[TB] FAIL pattern_done: got %0d cycles (seen=%0d) expected 545", cycles, ok);
    else passes++;
    for (int g = 0; g < NG; g++) begin
      e = expQ.pop_front();
      checks++;
      if (capQ.size() == 0) begin
        $display("[TB] FAIL pattern_capture: group %0d missing, expected word %h", g, e.word);
        continue;
      end
      c = capQ.pop_front();
      if (c.csel !== e.csel || c.word !== e.word)
        $display("[TB] FAIL pattern_word: got csel %0d word %h expected csel %0d word %h",
                 c.csel, c.word, e.csel, e.word);
      else passes++;
      checks++;
      if (c.edges != 16)
        $display("[TB] FAIL sclk_edges: group %0d got %0d expected 16", g, c.edges);
      else passes++;
      checks++;
      if (c.minHigh != 2 || c.maxHigh != 2 || c.latchLen != 2)
        $display("[TB] FAIL pulse_widths: group %0d high %0d..%0d latch %0d expected 2/2/2",
                 g, c.minHigh, c.maxHigh, c.latchLen);
      else passes++;
    end
    repeat (20) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || frameDone !== 1'b0)
      $display("[TB] FAIL idle_after_disable: busy %b done %b expected 0 0", busy, frameDone);
    else passes++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int cycles;
    logic [NG*GB-1:0] imgA, imgB;
    exp_t e;
    cap_t c;
    imgA = {$urandom, $urandom, $urandom, $urandom};
    imgB = ~imgA;
    image = imgA;
    capQ.delete();
    pushFrame(imgA);
    enableIn = 1'b1;
    waitBusy(ok);
    repeat (157) @(negedge clk);
    checks++;
    if (dispIf.csel_ob3 !== 3'd2)
      $display("[TB] FAIL mid_group2: csel got %0d expected 2", dispIf.csel_ob3);
    else passes++;
    image = imgB;
    pushFrame(imgB);
    waitFrameDone(cycles, ok);
    checks++;
    if (!ok) $display("[TB] FAIL b2b_first_done: seen 0 expected 1");
    else passes++;
    @(negedge clk);
    enableIn = 1'b0;
    waitFrameDone(cycles, ok);
    checks++;
    if (!ok || cycles + 1 != 546)
      $display("[TB] FAIL frame_period: got %0d cycles (seen=%0d) expected 546", cycles + 1, ok);
    else passes++;
    for (int g = 0; g < 2*NG; g++) begin
      e = expQ.pop_front();
      checks++;
      if (capQ.size() == 0) begin
        $display("[TB] FAIL b2b_capture: entry %0d missing, expected word %h", g, e.word);
        continue;
      end
      c = capQ.pop_front();
      if (c.csel !== e.csel || c.word !== e.word)
        $display("[TB] FAIL b2b_word: entry %0d got csel %0d word %h expected csel %0d word %h",
                 g, c.csel, c.word, e.csel, e.word);
      else passes++;
    end
  endtask

  task automatic test_blank();
    bit ok;
    int cycles;
    logic prevBlank;
    exp_t e;
    cap_t c;
    image = {$urandom, $urandom, $urandom, $urandom};
    capQ.delete();
    pushFrame(image);
    enableIn = 1'b1;
    waitBusy(ok);
    enableIn = 1'b0;
    repeat (100) @(negedge clk);
    prevBlank = blankIn;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (dispIf.blank_o !== prevBlank)
        $display("[TB] FAIL blank_follow: step %0d got %b expected %b", i, dispIf.blank_o, prevBlank);
      else passes++;
      blankIn = (i < 10) ? (i % 2 == 0) : 1'b0;
      prevBlank = blankIn;
    end
    waitFrameDone(cycles, ok);
    checks++;
    if (!ok) $display("[TB] FAIL blank_done: seen 0 expected 1");
    else passes++;
    for (int g = 0; g < NG; g++) begin
      e = expQ.pop_front();
      checks++;
      if (capQ.size() == 0) begin
        $display("[TB] FAIL blank_capture: group %0d missing, expected word %h", g, e.word);
        continue;
      end
      c = capQ.pop_front();
      if (c.csel !== e.csel || c.word !== e.word || c.edges != 16 ||
          c.minHigh != 2 || c.maxHigh != 2 || c.latchLen != 2)
        $display("[TB] FAIL blank_frame: got csel %0d word %h edges %0d high %0d..%0d latch %0d expected csel %0d word %h 16 2..2 2",
                 c.csel, c.word, c.edges, c.minHigh, c.maxHigh, c.latchLen, e.csel, e.word);
      else passes++;
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int cycles;
    logic [8:0] obs;
    exp_t e;
    cap_t c;
    image = {$urandom, $urandom, $urandom, $urandom};
    enableIn = 1'b1;
    waitBusy(ok);
    enableIn = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (dispIf.csel_ob3 == 3'd5) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) $display("[TB] FAIL reach_group5: csel %0d expected 5", dispIf.csel_ob3);
    else passes++;
    repeat (10) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    obs = {dispIf.latch_o, dispIf.sclk_o, dispIf.data_o, dispIf.csel_ob3,
           dispIf.blank_o, frameDone, busy};
    checks++;
    if (obs !== 9'b0_0_0_000_1_0_0)
      $display("[TB] FAIL async_reset: got %b expected %b", obs, 9'b0_0_0_000_1_0_0);
    else passes++;
    repeat (3) @(negedge clk);
    capQ.delete();
    rstn = 1'b1;
    pushFrame(image);
    enableIn = 1'b1;
    waitBusy(ok);
    enableIn = 1'b0;
    checks++;
    if (!ok || dispIf.csel_ob3 !== 3'd0 || dispIf.blank_o !== 1'b1)
      $display("[TB] FAIL restart: busy %0d csel %0d blank %b expected 1 0 1",
               ok, dispIf.csel_ob3, dispIf.blank_o);
    else passes++;
    waitFrameDone(cycles, ok);
    checks++;
    if (!ok || cycles != 545)
      $display("[TB] FAIL restart_done: got %0d cycles (seen=%0d) expected 545", cycles, ok);
    else passes++;
    for (int g = 0; g < NG; g++) begin
      e = expQ.pop_front();
      checks++;
      if (capQ.size() == 0) begin
        $display("[TB] FAIL restart_capture: group %0d missing, expected word %h", g, e.word);
        continue;
      end
      c = capQ.pop_front();
      if (c.csel !== e.csel || c.word !== e.word)
        $display("[TB] FAIL restart_word: got csel %0d word %h expected csel %0d word %h",
                 c.csel, c.word, e.csel, e.word);
      else passes++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_first_frame();
    test_pattern_timing();
    test_back_to_back();
    test_blank();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
